// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter : round-robin two-port sequencer for the data memory, LAT waits
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
  parameter int LAT       = 2,
  parameter int MEM_DEPTH = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [31:0]       p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_ack_o,
  output logic              p0_err_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_ack_o,
  output logic              p1_err_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_control_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              cpu_stall_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_LOAD  = 4'b0110;
  localparam logic [3:0] OP_STORE = 4'b0111;
  localparam logic [3:0] OP_IDLE  = 4'b1111;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic              grant;
  logic              gnt_port;
  logic [31:0]       sel_addr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE never grants, so a request still held at ack is not serviced twice.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    gnt_port = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (p0_req_i || p1_req_i) begin
          grant    = 1'b1;
          gnt_port = (p0_req_i && p1_req_i) ? ~last_q : p1_req_i;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_addr   = gnt_port ? p1_addr_i : p0_addr_i;
    last_d     = last_q;
    port_d     = port_q;
    we_d       = we_q;
    oor_d      = oor_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    if (grant) begin
      port_d  = gnt_port;
      last_d  = gnt_port;
      we_d    = gnt_port ? p1_we_i : p0_we_i;
      addr_d  = sel_addr;
      wdata_d = gnt_port ? p1_wdata_i : p0_wdata_i;
      oor_d   = (sel_addr >= 32'(MEM_DEPTH));
      cnt_d   = 4'(LAT);
    end
    if (state_q == ST_BUSY) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else if (!we_q) begin
        // Load result lands in the port register so it is visible during DONE.
        if (port_q) begin
          p1_rdata_d = oor_q ? '0 : mem_data_i;
        end else begin
          p0_rdata_d = oor_q ? '0 : mem_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q      <= 4'd0;
      last_q     <= 1'b1;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      port_q     <= port_d;
      we_q       <= we_d;
      oor_q      <= oor_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  always_comb begin
    mem_addr_o    = addr_q;
    mem_wdata_o   = wdata_q;
    mem_control_o = OP_IDLE;
    p0_ack_o      = 1'b0;
    p1_ack_o      = 1'b0;
    p0_err_o      = 1'b0;
    p1_err_o      = 1'b0;
    p0_rdata_o    = p0_rdata_q;
    p1_rdata_o    = p1_rdata_q;
    busy_o        = (state_q != ST_IDLE);
    if (state_q == ST_BUSY && cnt_q == 4'd0 && !oor_q) begin
      mem_control_o = we_q ? OP_STORE : OP_LOAD;
    end
    if (state_q == ST_DONE) begin
      p0_ack_o = ~port_q;
      p1_ack_o = port_q;
      p0_err_o = ~port_q & oor_q;
      p1_err_o = port_q & oor_q;
    end
  end

  assign cpu_stall_o = p0_req_i & ~p0_ack_o;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : directed bench for dmem_arbiter (LAT=2 and LAT=0 instances)
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          tests = 0;
  int          fails = 0;
  int          store_cnt = 0;

  // Instance A: LAT=2, backed by a 32-word bench memory
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err, busy_a, stall_a;
  logic [31:0] p0_rdata, p1_rdata, maddr_a, mwdata_a, mdata_a;
  logic [3:0]  ctl_a;
  logic [31:0] mem [0:31];

  // Instance B: LAT=0, constant read data
  logic        b_req;
  logic        b0_ack, b0_err, b1_ack, b1_err, busy_b, stall_b;
  logic [31:0] b0_rdata, b1_rdata, maddr_b, mwdata_b;
  logic [3:0]  ctl_b;
  logic [9:0]  ack_vec, op_vec, stall_vec;

  always #5 clk = ~clk;

  dmem_arbiter #(.LAT(2), .MEM_DEPTH(32), .DATA_W(32)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_ack_o(p0_ack), .p0_err_o(p0_err), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_ack_o(p1_ack), .p1_err_o(p1_err), .p1_rdata_o(p1_rdata),
    .mem_addr_o(maddr_a), .mem_wdata_o(mwdata_a), .mem_control_o(ctl_a),
    .mem_data_i(mdata_a), .busy_o(busy_a), .cpu_stall_o(stall_a)
  );

  dmem_arbiter #(.LAT(0), .MEM_DEPTH(32), .DATA_W(32)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .p0_req_i(b_req), .p0_we_i(1'b0), .p0_addr_i(32'd3), .p0_wdata_i(32'd0),
    .p0_ack_o(b0_ack), .p0_err_o(b0_err), .p0_rdata_o(b0_rdata),
    .p1_req_i(1'b0), .p1_we_i(1'b0), .p1_addr_i(32'd0), .p1_wdata_i(32'd0),
    .p1_ack_o(b1_ack), .p1_err_o(b1_err), .p1_rdata_o(b1_rdata),
    .mem_addr_o(maddr_b), .mem_wdata_o(mwdata_b), .mem_control_o(ctl_b),
    .mem_data_i(32'h0000_BEEF), .busy_o(busy_b), .cpu_stall_o(stall_b)
  );

  assign mdata_a = (maddr_a < 32) ? mem[maddr_a[4:0]] : 32'd0;

  always @(posedge clk) begin
    if (ctl_a == 4'b0111) begin
      store_cnt = store_cnt + 1;
      if (maddr_a < 32) mem[maddr_a[4:0]] = mwdata_a;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    b_req = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_ctl", ctl_a, 4'hF);
    chk("rst_addr", maddr_a, 0);
    chk("rst_ack", p0_ack, 0);
    chk("rst_rdata", p0_rdata, 0);
    chk("rst_stall", stall_a, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // p0 store addr 4 = 0xA5
    p0_req = 1; p0_we = 1; p0_addr = 4; p0_wdata = 32'hA5; #1;
    chk("st_c0_stall", stall_a, 1);
    chk("st_c0_ctl", ctl_a, 4'hF);
    tick(); chk("st_c1_ctl", ctl_a, 4'hF); chk("st_c1_busy", busy_a, 1);
    tick(); chk("st_c2_ctl", ctl_a, 4'hF); chk("st_c2_stall", stall_a, 1);
    tick(); chk("st_c3_ctl", ctl_a, 4'h7); chk("st_c3_addr", maddr_a, 4);
    chk("st_c3_wdata", mwdata_a, 32'hA5); chk("st_c3_ack", p0_ack, 0);
    tick(); chk("st_c4_ack", p0_ack, 1); chk("st_c4_err", p0_err, 0);
    chk("st_c4_stall", stall_a, 0); chk("st_c4_ctl", ctl_a, 4'hF);
    p0_req = 0;
    tick(); chk("st_c5_busy", busy_a, 0); chk("st_c5_ack", p0_ack, 0);
    chk("st_mem4", mem[4], 32'hA5); chk("st_count", store_cnt, 1);

    // p0 load addr 4
    p0_req = 1; p0_we = 0; p0_addr = 4; p0_wdata = 32'h0;
    tick(); tick(); chk("ld_c2_ctl", ctl_a, 4'hF);
    tick(); chk("ld_c3_ctl", ctl_a, 4'h6);
    tick(); chk("ld_c4_ctl", ctl_a, 4'hF); chk("ld_c4_ack", p0_ack, 1);
    chk("ld_c4_rdata", p0_rdata, 32'hA5);
    p0_req = 0;
    tick(); tick(); tick(); chk("ld_c7_rdata", p0_rdata, 32'hA5); chk("ld_c7_ack", p0_ack, 0);

    // p1 store to out-of-range address 40
    p1_req = 1; p1_we = 1; p1_addr = 40; p1_wdata = 32'hDEAD_BEEF;
    tick(); chk("oor_c1_ctl", ctl_a, 4'hF);
    tick(); chk("oor_c2_ctl", ctl_a, 4'hF);
    tick(); chk("oor_c3_ctl", ctl_a, 4'hF);
    tick(); chk("oor_c4_ack", p1_ack, 1); chk("oor_c4_err", p1_err, 1);
    chk("oor_c4_p0ack", p0_ack, 0); chk("oor_c4_rdata", p1_rdata, 0);
    p1_req = 0;
    tick(); chk("oor_count", store_cnt, 1); chk("oor_p1_err_after", p1_err, 0);

    // simultaneous loads, two rounds
    mem[8] = 32'h1111_0008; mem[9] = 32'h2222_0009;
    p0_req = 1; p0_we = 0; p0_addr = 8; p1_req = 1; p1_we = 0; p1_addr = 9;
    tick(); tick(); tick(); tick();
    chk("tie1_p0_ack", p0_ack, 1); chk("tie1_p1_ack_early", p1_ack, 0);
    chk("tie1_p0_rdata", p0_rdata, 32'h1111_0008);
    p0_req = 0;
    tick(); tick(); tick(); tick(); chk("tie1_p1_wait", p1_ack, 0);
    tick(); chk("tie1_p1_ack", p1_ack, 1); chk("tie1_p1_rdata", p1_rdata, 32'h2222_0009);
    chk("tie1_p0_ack_late", p0_ack, 0);
    p1_req = 0;
    tick();
    p0_req = 1; p0_addr = 9; p1_req = 1; p1_addr = 8;
    tick(); tick(); tick(); tick();
    chk("tie2_p0_ack", p0_ack, 1); chk("tie2_p1_ack_early", p1_ack, 0);
    chk("tie2_p0_rdata", p0_rdata, 32'h2222_0009);
    p0_req = 0;
    tick(); tick(); tick(); tick(); tick();
    chk("tie2_p1_ack", p1_ack, 1); chk("tie2_p1_rdata", p1_rdata, 32'h1111_0008);
    p1_req = 0;
    tick();

    // p1 store aborted by reset while cnt=1
    p1_req = 1; p1_we = 1; p1_addr = 10; p1_wdata = 32'h55;
    tick(); tick();
    rst_n = 1'b0; #1;
    chk("abort_busy", busy_a, 0); chk("abort_ctl", ctl_a, 4'hF);
    chk("abort_addr", maddr_a, 0); chk("abort_wdata", mwdata_a, 0);
    chk("abort_p0_rdata", p0_rdata, 0); chk("abort_p1_rdata", p1_rdata, 0);
    chk("abort_p1_ack", p1_ack, 0);
    p1_req = 0;
    tick(); tick();
    rst_n = 1'b1;
    chk("abort_count", store_cnt, 1); chk("abort_mem10", mem[10], 0);
    p0_req = 1; p0_we = 0; p0_addr = 8; p1_req = 1; p1_we = 0; p1_addr = 9;
    tick(); tick(); tick(); tick();
    chk("post_rst_p0_ack", p0_ack, 1); chk("post_rst_p1_ack", p1_ack, 0);
    p0_req = 0;
    tick(); tick(); tick(); tick(); tick();
    chk("post_rst_p1_done", p1_ack, 1);
    p1_req = 0;
    tick();

    // LAT=0 instance, p0 request held for ten cycles
    b_req = 1; #1;
    ack_vec = '0; op_vec = '0; stall_vec = '0;
    for (int c = 0; c < 10; c++) begin
      ack_vec[c]   = b0_ack;
      op_vec[c]    = (ctl_b == 4'b0110);
      stall_vec[c] = stall_b;
      tick();
    end
    b_req = 0;
    chk("lat0_acks", {22'd0, ack_vec}, {22'd0, 10'b01_0010_0100});
    chk("lat0_ops", {22'd0, op_vec}, {22'd0, 10'b00_1001_0010});
    chk("lat0_stall", {22'd0, stall_vec}, {22'd0, 10'b10_1101_1011});
    chk("lat0_rdata", b0_rdata, 32'h0000_BEEF);
    chk("lat0_err", b0_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
